score_display_mux: RTL and testbench

Parametrised two-field score display driver for the board's multiplexed 7-segment bank. It accepts a current score and a high score as binary and converts each to BCD with a sequential double-dabble engine. It scans the digits with an internal refresh divider and drives active-low anodes and cathodes. It supersedes the fixed-width divider-plus-FSM pair, adding configurable digit count, saturation, leading-zero blanking and glitch-free atomic display updates.

---
 rtl/score_disp_pkg.sv | 40 ++++
 rtl/bin2bcd_seq.sv | 46 ++++
 rtl/score_display_mux.sv | 138 +++++++++++++
 tb/tb_score_display_mux.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared converter state type, segment encoder and power-of-ten helper
// for the multiplexed score display.
package score_disp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_CUR,
      ST_SHIFT_CUR,
      ST_LOAD_HI,
      ST_SHIFT_HI,
      ST_COMMIT
   } conv_state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a}; non-decimal codes light nothing.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_OFF;
      endcase
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned v;
      v = 1;
      for (int i = 0; i < n; i++) v = v * 10;
      return v;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential add-3/shift binary-to-BCD converter, one input bit per cycle.
// start loads bin; done is high on the last shift cycle, bcd is final the cycle after.
module bin2bcd_seq #(
   parameter int SCORE_W = 14,
   parameter int DIGITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SCORE_W-1:0]    bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0]  r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_adj;
   logic [CNT_W-1:0]    r_cnt;

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
      end else if (start) begin
         r_bin <= bin;
         r_bcd <= '0;
         r_cnt <= CNT_W'(SCORE_W);
      end else if (r_cnt != '0) begin
         {r_bcd, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
         r_cnt          <= r_cnt - CNT_W'(1);
      end
   end

   assign done = (r_cnt == CNT_W'(1));
   assign bcd  = r_bcd;

endmodule

// File: rtl/score_display_mux.sv
// Two-field 7-segment score driver: time-shared BCD conversion every 2*SCORE_W+4 cycles,
// atomic commit of both fields, registered scan output one slot per REFRESH_DIV cycles; no backpressure.
module score_display_mux
   import score_disp_pkg::*;
#(
   parameter int SCORE_W     = 14,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SCORE_W-1:0]    current_score,
   input  logic [SCORE_W-1:0]    high_score,
   output logic [6:0]            cathode,
   output logic [2*DIGITS-1:0]   AN
);
   localparam int BCD_W  = 4 * DIGITS;
   localparam int SLOTS  = 2 * DIGITS;
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int REF_W  = $clog2(REFRESH_DIV);
   localparam longint unsigned SAT_LIMIT = pow10(DIGITS);
   localparam logic [SCORE_W-1:0] SAT_BIN = SCORE_W'(SAT_LIMIT - 1);

   conv_state_t         r_state;
   logic [BCD_W-1:0]    r_cur_bcd;
   logic [BCD_W-1:0]    r_disp_cur;
   logic [BCD_W-1:0]    r_disp_hi;
   logic [REF_W-1:0]    r_refresh;
   logic [SLOT_W-1:0]   r_slot;
   logic [SLOTS-1:0]    r_an;
   logic [6:0]          r_cathode;

   logic                w_start;
   logic                w_done;
   logic [SCORE_W-1:0]  w_sel;
   logic [SCORE_W-1:0]  w_bin;
   logic [BCD_W-1:0]    w_bcd;
   logic                w_commit;
   logic [BCD_W-1:0]    w_cur_nxt;
   logic [BCD_W-1:0]    w_hi_nxt;
   logic                w_is_hi;
   logic [BCD_W-1:0]    w_field;
   logic [SLOT_W-1:0]   w_pos;
   logic [3:0]          w_digit;
   logic                w_upper_nz;
   logic                w_blank;
   logic [SLOTS-1:0]    w_an_nxt;
   logic [6:0]          w_seg_nxt;
   logic                w_wrap;

   // Out-of-range scores are clamped before conversion so the result is all nines.
   always_comb begin
      w_sel   = (r_state == ST_LOAD_HI) ? high_score : current_score;
      w_bin   = (64'(w_sel) >= SAT_LIMIT) ? SAT_BIN : w_sel;
      w_start = (r_state == ST_LOAD_CUR) || (r_state == ST_LOAD_HI);
   end

   bin2bcd_seq #(
      .SCORE_W (SCORE_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .bin   (w_bin),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cur_bcd  <= '0;
         r_disp_cur <= '0;
         r_disp_hi  <= '0;
      end else begin
         case (r_state)
            ST_IDLE:      r_state <= ST_LOAD_CUR;
            ST_LOAD_CUR:  r_state <= ST_SHIFT_CUR;
            ST_SHIFT_CUR: if (w_done) r_state <= ST_LOAD_HI;
            ST_LOAD_HI: begin
               r_cur_bcd <= w_bcd;
               r_state   <= ST_SHIFT_HI;
            end
            ST_SHIFT_HI:  if (w_done) r_state <= ST_COMMIT;
            ST_COMMIT: begin
               r_disp_cur <= r_cur_bcd;
               r_disp_hi  <= w_bcd;
               r_state    <= ST_IDLE;
            end
            default:      r_state <= ST_IDLE;
         endcase
      end
   end

   // A slot loaded on the commit edge must see the digits being committed.
   always_comb begin
      w_commit   = (r_state == ST_COMMIT);
      w_cur_nxt  = w_commit ? r_cur_bcd : r_disp_cur;
      w_hi_nxt   = w_commit ? w_bcd : r_disp_hi;
      w_is_hi    = (r_slot >= SLOT_W'(DIGITS));
      w_field    = w_is_hi ? w_hi_nxt : w_cur_nxt;
      w_pos      = w_is_hi ? (r_slot - SLOT_W'(DIGITS)) : r_slot;
      w_digit    = '0;
      w_upper_nz = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (SLOT_W'(i) == w_pos) w_digit = w_field[4*i +: 4];
         if ((SLOT_W'(i) >= w_pos) && (w_field[4*i +: 4] != 4'd0)) w_upper_nz = 1'b1;
      end
      w_blank  = (BLANK_LZ != 0) && (w_pos != '0) && !w_upper_nz;
      w_an_nxt = '1;
      if (!w_blank) w_an_nxt[r_slot] = 1'b0;
      w_seg_nxt = w_blank ? SEG_OFF : seg_encode(w_digit);
      w_wrap    = (r_refresh == REF_W'(REFRESH_DIV - 1));
   end

   // r_slot names the slot that goes on the outputs at the next wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refresh <= '0;
         r_slot    <= '0;
         r_an      <= '1;
         r_cathode <= SEG_OFF;
      end else if (w_wrap) begin
         r_refresh <= '0;
         r_slot    <= (r_slot == SLOT_W'(SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
         r_an      <= w_an_nxt;
         r_cathode <= w_seg_nxt;
      end else begin
         r_refresh <= r_refresh + REF_W'(1);
      end
   end

   assign AN      = r_an;
   assign cathode = r_cathode;

endmodule

// File: tb/tb_score_display_mux.sv
// Randomised bench for score_display_mux with an arithmetic model of the expected scan.
module tb_score_display_mux;
   localparam int SW  = 14;
   localparam int DG  = 4;
   localparam int RD  = 4;
   localparam int NS  = 2 * DG;
   localparam int LIM = 9999;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [SW-1:0] current_score = '0;
   logic [SW-1:0] high_score = '0;
   logic [6:0]    cathode, cathode_nb;
   logic [NS-1:0] an, an_nb;

   int cyc;
   int n_checks = 0;
   int n_fail = 0;

   logic [NS-1:0] obs_an    [NS];
   logic [6:0]    obs_cat   [NS];
   logic [NS-1:0] obs_an_nb [NS];
   logic [6:0]    obs_cat_nb[NS];

   int tv_cur[4] = '{1234, 16383, 9999, 0};
   int tv_hi [4] = '{5678, 10000, 10000, 16383};

   score_display_mux #(.SCORE_W(SW), .DIGITS(DG), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
      .clk(clk), .rst(rst), .current_score(current_score), .high_score(high_score),
      .cathode(cathode), .AN(an));

   score_display_mux #(.SCORE_W(SW), .DIGITS(DG), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .rst(rst), .current_score(current_score), .high_score(high_score),
      .cathode(cathode_nb), .AN(an_nb));

   always #5 clk = ~clk;

   // Cycles since reset release; after edge n the slot on display is n/RD-1 (mod NS).
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic void model_slot(input int cur, input int hi, input int k, input bit blz,
                                      output logic [NS-1:0] e_an, output logic [6:0] e_cat);
      int v, p, j;
      v = (k < DG) ? cur : hi;
      if (v > LIM) v = LIM;
      j = k % DG;
      p = 1;
      for (int i = 0; i < j; i++) p = p * 10;
      e_an  = '1;
      e_cat = 7'b1111111;
      if (!(blz && j != 0 && v < p)) begin
         e_an[k] = 1'b0;
         e_cat   = seg_of((v / p) % 10);
      end
   endfunction

   task automatic observe_scan(input int min_cyc, output bit ok);
      int guard;
      ok = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!(cyc >= min_cyc && cyc >= RD && cyc % RD == 0 && ((cyc / RD - 1) % NS) == 0)
             && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) return;
      for (int k = 0; k < NS; k++) begin
         obs_an[k] = an;    obs_cat[k] = cathode;
         obs_an_nb[k] = an_nb; obs_cat_nb[k] = cathode_nb;
         if (k != NS - 1) repeat (RD) @(negedge clk);
      end
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      current_score = '0;
      high_score = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (an !== 8'hFF || cathode !== 7'b1111111) begin
         n_fail++;
         $display("FAIL reset_hold: an=%b cat=%b required an=11111111 cat=1111111", an, cathode);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (an !== 8'hFF || cathode !== 7'b1111111) begin
         n_fail++;
         $display("FAIL pre_first_slot: an=%b cat=%b required an=11111111 cat=1111111", an, cathode);
      end
      @(negedge clk);
      n_checks++;
      if (an !== 8'b11111110 || cathode !== 7'b1000000) begin
         n_fail++;
         $display("FAIL first_slot: an=%b cat=%b required an=11111110 cat=1000000", an, cathode);
      end
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         n_checks++;
         if (an !== 8'hFF && an !== 8'b11111110 && an !== 8'b11101111) begin
            n_fail++;
            $display("FAIL zero_blank cyc=%0d: an=%b required only unit anodes", cyc, an);
         end
      end
   endtask

   task automatic test_conversion();
      bit ok;
      logic [NS-1:0] e_an;
      logic [6:0] e_cat;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         current_score = SW'(tv_cur[t]);
         high_score = SW'(tv_hi[t]);
         repeat (70) @(negedge clk);
         observe_scan(0, ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL conv_scan_timeout: found=0 required=1");
         end
         for (int k = 0; k < NS; k++) begin
            model_slot(tv_cur[t], tv_hi[t], k, 1'b1, e_an, e_cat);
            n_checks++;
            if (obs_an[k] !== e_an || (e_an !== 8'hFF && obs_cat[k] !== e_cat)) begin
               n_fail++;
               $display("FAIL conv slot%0d cur=%0d hi=%0d: an=%b cat=%b required an=%b cat=%b",
                        k, tv_cur[t], tv_hi[t], obs_an[k], obs_cat[k], e_an, e_cat);
            end
         end
      end
   endtask

   task automatic test_blanking();
      bit ok;
      logic [NS-1:0] e_an;
      logic [6:0] e_cat;
      @(negedge clk);
      current_score = SW'(7);
      high_score = '0;
      repeat (70) @(negedge clk);
      observe_scan(0, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL blank_scan_timeout: found=0 required=1");
      end
      for (int k = 0; k < NS; k++) begin
         model_slot(7, 0, k, 1'b1, e_an, e_cat);
         n_checks++;
         if (obs_an[k] !== e_an || (e_an !== 8'hFF && obs_cat[k] !== e_cat)) begin
            n_fail++;
            $display("FAIL blank_lz1 slot%0d: an=%b cat=%b required an=%b cat=%b",
                     k, obs_an[k], obs_cat[k], e_an, e_cat);
         end
         model_slot(7, 0, k, 1'b0, e_an, e_cat);
         n_checks++;
         if (obs_an_nb[k] !== e_an || obs_cat_nb[k] !== e_cat) begin
            n_fail++;
            $display("FAIL blank_lz0 slot%0d: an=%b cat=%b required an=%b cat=%b",
                     k, obs_an_nb[k], obs_cat_nb[k], e_an, e_cat);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int cur, hi, mode;
      logic [NS-1:0] e_an;
      logic [6:0] e_cat;
      for (int t = 0; t < 6; t++) begin
         mode = int'($urandom_range(0, 2));
         cur = (mode == 0) ? int'($urandom_range(0, 16383)) :
               (mode == 1) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 9));
         hi  = int'($urandom_range(0, 16383));
         if (mode == 2) hi = int'($urandom_range(0, 999));
         @(negedge clk);
         current_score = SW'(cur);
         high_score = SW'(hi);
         repeat (70) @(negedge clk);
         observe_scan(0, ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL rand_scan_timeout: found=0 required=1");
         end
         for (int k = 0; k < NS; k++) begin
            model_slot(cur, hi, k, 1'b1, e_an, e_cat);
            n_checks++;
            if (obs_an[k] !== e_an || (e_an !== 8'hFF && obs_cat[k] !== e_cat)) begin
               n_fail++;
               $display("FAIL rand slot%0d cur=%0d hi=%0d: an=%b cat=%b required an=%b cat=%b",
                        k, cur, hi, obs_an[k], obs_cat[k], e_an, e_cat);
            end
         end
      end
   endtask

   task automatic test_atomic();
      int chg, slot, p;
      bit seen_new;
      logic [NS-1:0] e_an;
      logic [6:0] od, nd;
      @(negedge clk);
      current_score = SW'(1999);
      high_score = SW'(1999);
      repeat (70) @(negedge clk);
      chg = int'($urandom_range(1, 8));
      seen_new = 1'b0;
      for (int s = 0; s < 40; s++) begin
         do @(negedge clk); while (cyc % RD != 0 || cyc < RD);
         slot = (cyc / RD - 1) % NS;
         if (slot < DG) begin
            p = 1;
            for (int i = 0; i < slot; i++) p = p * 10;
            od = seg_of((1999 / p) % 10);
            nd = seg_of((2000 / p) % 10);
            e_an = '1;
            e_an[slot] = 1'b0;
            n_checks++;
            if (an !== e_an) begin
               n_fail++;
               $display("FAIL atomic_anode slot%0d: an=%b required %b", slot, an, e_an);
            end else if (cathode === nd) begin
               seen_new = 1'b1;
            end else if (cathode !== od || seen_new) begin
               n_fail++;
               $display("FAIL atomic_mix slot%0d: cat=%b required old %b before any new %b",
                        slot, cathode, od, nd);
            end
         end
         if (s == chg) current_score = SW'(2000);
      end
      n_checks++;
      if (!seen_new) begin
         n_fail++;
         $display("FAIL atomic_update: new_seen=%0d required=1", seen_new);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      int guard;
      logic [NS-1:0] e_an;
      logic [6:0] e_cat;
      @(negedge clk);
      current_score = SW'(4321);
      high_score = SW'(5678);
      repeat (70) @(negedge clk);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc % 32 != 25 && guard < 64);
      n_checks++;
      if (cyc % 32 != 25 || an !== 8'b11011111 || cathode !== 7'b1111000) begin
         n_fail++;
         $display("FAIL pre_reset_slot5: an=%b cat=%b required an=11011111 cat=1111000", an, cathode);
      end
      #2;
      rst = 1'b1;
      current_score = SW'(1111);
      high_score = SW'(2222);
      #1;
      n_checks++;
      if (an !== 8'hFF || cathode !== 7'b1111111) begin
         n_fail++;
         $display("FAIL async_reset: an=%b cat=%b required an=11111111 cat=1111111", an, cathode);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (an !== 8'b11111110 || cathode !== 7'b1000000) begin
         n_fail++;
         $display("FAIL post_reset_slot0: an=%b cat=%b required an=11111110 cat=1000000", an, cathode);
      end
      observe_scan(33, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL post_reset_scan_timeout: found=0 required=1");
      end
      for (int k = 0; k < NS; k++) begin
         model_slot(1111, 2222, k, 1'b1, e_an, e_cat);
         n_checks++;
         if (obs_an[k] !== e_an || obs_cat[k] !== e_cat) begin
            n_fail++;
            $display("FAIL post_reset_commit slot%0d: an=%b cat=%b required an=%b cat=%b",
                     k, obs_an[k], obs_cat[k], e_an, e_cat);
         end
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      test_reset();
      test_conversion();
      test_blanking();
      test_random();
      test_atomic();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
